// File: rtl/apb3_manager_bridge.sv
// apb3_manager_bridge: one-outstanding request/response port bridged onto an APB3 manager.
// Define APB3_MANAGER_TIMEOUT_EN to bound the ACCESS-phase wait to TimeoutCycles cycles.
module apb3_manager_bridge #(
    parameter int unsigned AddressWidth  = 20,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic                    req_write,
    input  logic [DataWidth-1:0]    req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DataWidth-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic [AddressWidth-1:0] paddr,
    output logic                    pselx,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DataWidth-1:0]    pwdata,
    input  logic                    pready,
    input  logic [DataWidth-1:0]    prdata,
    input  logic                    pslverr
);

    if (DataWidth != 8 && DataWidth != 16 && DataWidth != 24 && DataWidth != 32) begin : g_bad_dw
        $error("apb3_manager_bridge: DataWidth must be 8, 16, 24 or 32");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_req_ready, w_req_ready_nxt;
    logic                    r_psel, w_psel_nxt;
    logic                    r_penable, w_penable_nxt;
    logic                    r_pwrite, w_pwrite_nxt;
    logic [AddressWidth-1:0] r_paddr, w_paddr_nxt;
    logic [DataWidth-1:0]    r_pwdata, w_pwdata_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic [DataWidth-1:0]    r_rsp_rdata, w_rsp_rdata_nxt;
    logic                    r_rsp_error, w_rsp_error_nxt;
    logic                    w_tmo_hit;

`ifdef APB3_MANAGER_TIMEOUT_EN
    if (TimeoutCycles == 0) begin : g_bad_tmo
        $error("apb3_manager_bridge: TimeoutCycles must be at least 1");
    end

    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    logic [TmoW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;

    // Fires in the ACCESS cycle that completes the TimeoutCycles-th stalled cycle.
    assign w_tmo_hit = (r_tmo_cnt == TmoLast);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign w_unused_tmo = |TimeoutCycles;
`endif

    // State and every bus-facing output are registered from the next-state logic.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_error <= w_rsp_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = 1'b0;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_error_nxt = r_rsp_error;

        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_state_nxt  = S_SETUP;
                    w_psel_nxt   = 1'b1;
                    w_paddr_nxt  = req_addr;
                    w_pwrite_nxt = req_write;
                    w_pwdata_nxt = req_wdata;
                end else begin
                    w_req_ready_nxt = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            S_ACCESS: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                if (pready) begin
                    w_state_nxt     = S_RESP;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = pslverr;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
                end else if (w_tmo_hit) begin
                    w_state_nxt     = S_RESP;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_req_ready_nxt = 1'b1;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef APB3_MANAGER_TIMEOUT_EN
    // Counts stalled ACCESS cycles; restarts whenever a new transfer enters SETUP.
    always_comb begin
        w_tmo_cnt_nxt = r_tmo_cnt;
        if (w_state_nxt == S_SETUP) begin
            w_tmo_cnt_nxt = '0;
        end else if (r_state == S_ACCESS && !pready) begin
            w_tmo_cnt_nxt = r_tmo_cnt + TmoW'(1);
        end
    end
`endif

    assign req_ready = r_req_ready;
    assign pselx     = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_apb3_manager_bridge.sv
// tb_apb3_manager_bridge: random and directed transfers against an APB slave/memory model,
// with a response scoreboard and APB protocol monitor running as independent processes.
module tb_apb3_manager_bridge;

    localparam int unsigned AW  = 20;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        int            waits;
        logic          err;
    } txn_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            due;
    } exp_t;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [AW-1:0] paddr;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    apb3_manager_bridge #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .TimeoutCycles(TMO)
    ) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_write(req_write),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .paddr    (paddr),
        .pselx    (pselx),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;

    int      checks   = 0;
    int      failures = 0;
    int      cyc      = 0;
    int      rr_mode  = 1;   // 0 random rsp_ready, 1 always ready, 2 never ready
    int      acc_cnt  = 0;
    int      last_acc = 0;
    bit      in_rsp   = 1'b0;
    bit      prev_psel = 1'b0;
    exp_t    cur_exp;
    exp_t    exp_q[$];
    txn_t    sq[$];
    logic [DW-1:0] mem [16];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    always @(posedge pclk) cyc <= cyc + 1;

    always @(posedge pclk) begin
        #1;
        case (rr_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            2:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    // APB slave model: memory of 16 words decoded on paddr[3:0], protocol checks each cycle.
    always @(negedge pclk) begin
        if (presetn) begin
            if (penable) chk("penable_implies_psel", 64'(pselx), 64'd1);
            if (pselx && !penable) begin
                if (sq.size() == 0) begin
                    chk("setup_without_request", 64'd1, 64'd0);
                end else begin
                    chk("setup_paddr", 64'(paddr), 64'(sq[0].addr));
                    chk("setup_pwrite", 64'(pwrite), 64'(sq[0].wr));
                    chk("setup_pwdata", 64'(pwdata), 64'(sq[0].wdata));
                end
            end
            if (pselx && penable) begin
                chk("setup_before_access", 64'(prev_psel), 64'd1);
                if (sq.size() == 0) begin
                    chk("access_without_request", 64'd1, 64'd0);
                    pready = 1'b1;
                end else begin
                    chk("access_paddr_stable", 64'(paddr), 64'(sq[0].addr));
                    chk("access_pwrite_stable", 64'(pwrite), 64'(sq[0].wr));
                    chk("access_pwdata_stable", 64'(pwdata), 64'(sq[0].wdata));
                    if (acc_cnt >= sq[0].waits) begin
                        pready  = 1'b1;
                        pslverr = sq[0].err;
                        prdata  = sq[0].wr ? DW'($urandom) : mem[sq[0].addr[3:0]];
                        if (sq[0].wr && !sq[0].err) mem[sq[0].addr[3:0]] = sq[0].wdata;
                        void'(sq.pop_front());
                        acc_cnt = 0;
                    end else begin
                        pready  = 1'b0;
                        pslverr = 1'($urandom);
                        prdata  = DW'($urandom);
                        acc_cnt++;
                    end
                end
            end else begin
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
                prdata  = DW'($urandom);
            end
            prev_psel = pselx;
        end
    end

    // Response scoreboard: pops one expectation per response and checks it every held cycle.
    always @(negedge pclk) begin
        if (presetn && rsp_valid) begin
            chk("rsp_valid_vs_req_ready", 64'(req_ready), 64'd0);
            chk("psel_low_in_resp", 64'(pselx | penable), 64'd0);
            if (!in_rsp) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    cur_exp = exp_q.pop_front();
                    in_rsp  = 1'b1;
                    chk("rsp_latency", 64'(cyc), 64'(cur_exp.due));
                end
            end
            if (in_rsp) begin
                chk("rsp_rdata", 64'(rsp_rdata), 64'(cur_exp.rdata));
                chk("rsp_error", 64'(rsp_error), 64'(cur_exp.err));
                if (rsp_ready) in_rsp = 1'b0;
            end
        end
    end

    // mode 0: normal completion, 1: no response expected, 2: timeout error expected.
    task automatic send(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                        input int waits, input logic err, input int mode);
        int   n;
        txn_t t;
        exp_t e;
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            chk("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        t.addr = a; t.wr = w; t.wdata = d; t.waits = waits; t.err = err;
        sq.push_back(t);
        last_acc = cyc + 1;
        if (mode == 0) begin
            e.rdata = w ? '0 : mem[a[3:0]];
            e.err   = err;
            e.due   = last_acc + 2 + waits;
            exp_q.push_back(e);
        end else if (mode == 2) begin
            e.rdata = '0;
            e.err   = 1'b1;
            e.due   = last_acc + 2 + int'(TMO) - 1;
            exp_q.push_back(e);
        end
        @(posedge pclk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!(exp_q.size() == 0 && !in_rsp && req_ready) && n < 3000);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        #1;
        chk("rst_pselx", 64'(pselx), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        sq.delete();
        acc_cnt   = 0;
        in_rsp    = 1'b0;
        prev_psel = 1'b0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        int prev;
        presetn   = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA500_0000 | DW'(i);
        #3;
        do_reset();

        // Zero-wait read of a known word
        mem[4] = 32'hDEAD_BEEF;
        send(20'h00004, 1'b0, 32'h0BAD_F00D, 0, 1'b0, 0);
        wait_idle();

        // Write with three stalled ACCESS cycles, then read it back
        send(20'h00010, 1'b1, 32'h1234_5678, 3, 1'b0, 0);
        wait_idle();
        send(20'h00010, 1'b0, 32'h0, 1, 1'b0, 0);
        wait_idle();

        // Erroring read held for five cycles with rsp_ready low
        rr_mode = 2;
        send(20'h00020, 1'b0, 32'h0, 1, 1'b1, 0);
        n = 0;
        while (!in_rsp && n < 50) begin
            @(negedge pclk);
            n++;
        end
        chk("held_rsp_seen", 64'(in_rsp), 64'd1);
        repeat (5) @(negedge pclk);
        rr_mode = 1;
        wait_idle();

        // Back-to-back zero-wait transfers: one per four cycles
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            send(AW'($urandom), 1'($urandom), DW'($urandom), 0, 1'b0, 0);
            if (i > 0) chk("b2b_period", 64'(last_acc - prev), 64'd4);
            prev = last_acc;
        end
        wait_idle();

        // Randomized traffic with random waits, errors and response back-pressure
        rr_mode = 0;
        for (int i = 0; i < 150; i++) begin
            send(AW'($urandom), 1'($urandom), DW'($urandom), $urandom_range(0, 3),
                 1'($urandom_range(0, 7) == 0), 0);
        end
        wait_idle();
        rr_mode = 1;

        // Reset in the middle of ACCESS abandons the transfer
        send(20'h00030, 1'b0, 32'h0, 20, 1'b0, 1);
        n = 0;
        while (!(pselx && penable) && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("reached_access", 64'(pselx & penable), 64'd1);
        #2;
        do_reset();
        repeat (5) @(negedge pclk);
        @(posedge pclk);
        #1;
        send(20'h00031, 1'b1, 32'hCAFE_0001, 0, 1'b0, 0);
        send(20'h00031, 1'b0, 32'h0, 2, 1'b0, 0);
        wait_idle();

        // Slave that never raises pready
`ifdef APB3_MANAGER_TIMEOUT_EN
        send(20'h00040, 1'b0, 32'h0, 1 << 30, 1'b0, 2);
        wait_idle();
`else
        send(20'h00040, 1'b0, 32'h0, 1 << 30, 1'b0, 1);
        repeat (1000) @(negedge pclk);
        chk("stuck_no_rsp", 64'(rsp_valid), 64'd0);
        chk("stuck_in_access", 64'(pselx & penable), 64'd1);
`endif
        do_reset();
        send(20'h00041, 1'b0, 32'h0, 0, 1'b0, 0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
